// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for the Harvard MIPS CPU: cleared after reset, filled over a
// valid/ready load stream, then served read-only with a combinational fetch port.
module mips_cpu_instr_memory #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_enable,
    input  logic [31:0]                  instr_address,
    output logic [31:0]                  instr_readdata,
    input  logic                         load_valid,
    input  logic [31:0]                  load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic [$clog2(DEPTH_WORDS):0] load_count,
    output logic                         mem_ready,
    output logic                         fault
);
    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam int              CW       = AW + 1;
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH_WORDS - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH_WORDS);
    localparam logic [31:0]     SPAN     = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t        state, state_next;
    logic [AW-1:0] ptr;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          xfer;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [31:0]   offset;
    logic          in_range;
    logic          aligned;
    logic          addr_zero;

    // Loaded words arrive in assembler (big-endian) order; the CPU consumes them swapped.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign xfer = load_valid && load_ready && clk_enable;

    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR:   if (clk_enable && ptr == LAST_PTR) state_next = LOAD;
            LOAD:    if (xfer && (load_last || ptr == LAST_PTR)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            ptr        <= '0;
            load_count <= '0;
            load_ready <= 1'b0;
            mem_ready  <= 1'b0;
            fault      <= 1'b0;
        end else if (clk_enable) begin
            state      <= state_next;
            load_ready <= (state_next == LOAD);
            mem_ready  <= (state_next == RUN);
            unique case (state)
                CLEAR: ptr <= ptr + AW'(1);
                LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + AW'(1);
                        if (load_count != FULL_CNT) load_count <= load_count + CW'(1);
                    end
                end
                RUN: begin
                    if (!addr_zero && (!aligned || !in_range)) fault <= 1'b1;
                end
                default: ptr <= '0;
            endcase
        end
    end

    // Single write port shared by the clear sweep and the load stream; reset discards the write.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 32'h0000_0000;
        if (!reset && clk_enable) begin
            if (state == CLEAR) begin
                wr_en = 1'b1;
            end else if (state == LOAD && xfer) begin
                wr_en   = 1'b1;
                wr_data = byte_swap(load_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= wr_data;
    end

    assign offset    = instr_address - BASE_ADDR;
    assign in_range  = (offset < SPAN);
    assign aligned   = (offset[1:0] == 2'b00);
    assign addr_zero = (instr_address == 32'h0000_0000);

    // Address 0 is the CPU halt address and must always fetch a NOP.
    assign instr_readdata = (state == RUN && in_range && aligned && !addr_zero)
                            ? mem[offset[AW+1:2]] : 32'h0000_0000;
endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed bench for mips_cpu_instr_memory: clear timing, load/swap, fetch faults,
// saturation, mid-load reset and clock-enable freeze.
module tb_mips_cpu_instr_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [8:0]  load_count;
    logic        mem_ready;
    logic        fault;

    int checks = 0;
    int errors = 0;

    mips_cpu_instr_memory #(.DEPTH_WORDS(256), .BASE_ADDR(32'hBFC00000)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_count     (load_count),
        .mem_ready      (mem_ready),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_load_ready(output int n);
        n = 0;
        while (!load_ready && n < 600) begin
            tick();
            n++;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        instr_address = addr;
        #1;
        check(tag, instr_readdata, exp);
    endtask

    initial begin
        int   n;
        int   accepted;
        logic seen_ready;
        logic seen_mem_ready;
        logic seen_data;

        reset = 1'b1; clk_enable = 1'b1; instr_address = 32'hBFC00000;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        do_reset();
        check("rst_load_ready", load_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_fault", fault, 0);
        check("rst_load_count", load_count, 0);

        // CLEAR window: 256 cycles of load_ready=0, reads all zero
        seen_ready = 0; seen_mem_ready = 0; seen_data = 0;
        for (int i = 0; i < 256; i++) begin
            instr_address = 32'hBFC00000 + 32'(4 * (i % 8)) + ((i % 3 == 0) ? 32'd2 : 32'd0);
            #1;
            seen_ready     = seen_ready | load_ready;
            seen_mem_ready = seen_mem_ready | mem_ready;
            seen_data      = seen_data | (instr_readdata != 0);
            tick();
        end
        check("clear_no_early_ready", seen_ready, 0);
        check("clear_mem_ready_low", seen_mem_ready, 0);
        check("clear_reads_zero", seen_data, 0);
        check("clear_done_ready", load_ready, 1);
        check("clear_no_fault", fault, 0);

        // Load 4 words, last on the fourth
        send_word(32'h24420008, 0);
        send_word(32'h24420002, 0);
        send_word(32'h00000008, 0);
        check("load_not_ready_yet", mem_ready, 0);
        send_word(32'h24000000, 1);
        check("load_mem_ready", mem_ready, 1);
        check("load_ready_drop", load_ready, 0);
        check("load_count4", load_count, 4);
        read_check("rd_w0", 32'hBFC00000, 32'h08004224);
        read_check("rd_w1", 32'hBFC00004, 32'h02004224);
        read_check("rd_w2", 32'hBFC00008, 32'h08000000);
        read_check("rd_w3", 32'hBFC0000C, 32'h00000024);
        read_check("rd_w4_clear", 32'hBFC00010, 32'h00000000);
        tick();
        check("run_no_fault", fault, 0);

        // Misaligned fetch
        read_check("rd_misaligned", 32'hBFC00002, 32'h00000000);
        tick();
        check("fault_misaligned", fault, 1);
        instr_address = 32'hBFC00000;
        tick(); tick();
        check("fault_sticky", fault, 1);
        check("rd_after_fault", instr_readdata, 32'h08004224);

        // Fresh CLEAR with 10-cycle clk_enable freeze
        do_reset();
        check("rst2_fault", fault, 0);
        check("rst2_load_count", load_count, 0);
        n = 0;
        while (!load_ready && n < 600) begin
            clk_enable = !(n >= 100 && n < 110);
            tick();
            n++;
        end
        clk_enable = 1'b1;
        check("clear_freeze_len", n, 266);

        // Two words, then reset with a simultaneous transfer
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        check("partial_count", load_count, 2);
        reset = 1'b1; load_valid = 1'b1; load_data = 32'h99AABBCC;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        check("midload_rst_count", load_count, 0);
        check("midload_rst_ready", load_ready, 0);
        wait_load_ready(n);
        check("clear3_len", n, 256);
        send_word(32'hAABBCCDD, 1);
        check("reload_mem_ready", mem_ready, 1);
        check("reload_count", load_count, 1);
        read_check("reload_w0", 32'hBFC00000, 32'hDDCCBBAA);
        read_check("reload_w1_cleared", 32'hBFC00004, 32'h00000000);
        read_check("reload_w2_cleared", 32'hBFC00008, 32'h00000000);

        // Halt address and out-of-range fetches
        read_check("rd_addr0", 32'h00000000, 32'h00000000);
        tick();
        check("addr0_no_fault", fault, 0);
        read_check("rd_below_base", 32'hBFBFFFFC, 32'h00000000);
        instr_address = 32'hBFC003FC;
        tick();
        check("top_word_no_fault", fault, 0);
        read_check("rd_out_of_range", 32'hBFC00400, 32'h00000000);
        tick();
        check("fault_out_of_range", fault, 1);

        // 300-word stream without load_last: saturates at 256; bad address ignored outside RUN
        do_reset();
        instr_address = 32'h00000003;
        wait_load_ready(n);
        check("clear4_len", n, 256);
        accepted = 0;
        load_valid = 1'b1; load_last = 1'b0;
        for (int i = 0; i < 300; i++) begin
            load_data = 32'(i + 1);
            if (!load_ready && accepted != 0) instr_address = 32'hBFC00000;
            #1;
            if (load_ready) accepted++;
            tick();
        end
        load_valid = 1'b0;
        check("stream_accepted", accepted, 256);
        check("stream_count_sat", load_count, 256);
        check("stream_mem_ready", mem_ready, 1);
        check("stream_ready_low", load_ready, 0);
        check("stream_no_fault", fault, 0);
        read_check("stream_w0", 32'hBFC00000, 32'h01000000);
        read_check("stream_w255", 32'hBFC003FC, 32'h00010000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
